// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Segment patterns are ordered {a,b,c,d,e,f,g} with a in bit 1.
package seg7_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:7] SEG_0     = 7'b1111110;
  localparam logic [1:7] SEG_1     = 7'b0110000;
  localparam logic [1:7] SEG_2     = 7'b1101101;
  localparam logic [1:7] SEG_3     = 7'b1111001;
  localparam logic [1:7] SEG_4     = 7'b0110011;
  localparam logic [1:7] SEG_5     = 7'b1011011;
  localparam logic [1:7] SEG_6     = 7'b1011111;
  localparam logic [1:7] SEG_6_NT  = 7'b0011111;
  localparam logic [1:7] SEG_7     = 7'b1110000;
  localparam logic [1:7] SEG_8     = 7'b1111111;
  localparam logic [1:7] SEG_9     = 7'b1111011;
  localparam logic [1:7] SEG_9_NT  = 7'b1110011;
  localparam logic [1:7] SEG_E     = 7'b1001111;
  localparam logic [1:7] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_ERR   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Valid/ready port carrying one decoded digit per transfer.
interface seg7_scan_capture_if #(
  parameter int unsigned IW = 2
) ();
  logic          valid;
  logic          ready;
  logic [IW-1:0] idx;
  logic [3:0]    code;
  logic          err;

  modport master (output valid, idx, code, err, input ready);
  modport slave  (input valid, idx, code, err, output ready);
endinterface

// File: rtl/seg7_to_code.sv
// Combinational decode of a segment pattern to a digit code plus illegal flag.
module seg7_to_code
  import seg7_pkg::*;
(
  input  logic [1:7] i_seg,
  output logic [3:0] o_code_c,
  output logic       o_err_c
);

  always_comb begin
    o_code_c = CODE_ERR;
    o_err_c  = 1'b0;
    case (i_seg)
      SEG_0:              o_code_c = 4'h0;
      SEG_1:              o_code_c = 4'h1;
      SEG_2:              o_code_c = 4'h2;
      SEG_3:              o_code_c = 4'h3;
      SEG_4:              o_code_c = 4'h4;
      SEG_5:              o_code_c = 4'h5;
      SEG_6, SEG_6_NT:    o_code_c = 4'h6;
      SEG_7:              o_code_c = 4'h7;
      SEG_8:              o_code_c = 4'h8;
      SEG_9, SEG_9_NT:    o_code_c = 4'h9;
      SEG_E:              o_code_c = CODE_ERR;
      SEG_BLANK:          o_code_c = CODE_BLANK;
      default:            o_err_c  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed 7-segment bus, waits for each strobe/pattern to settle,
// and reports the decoded digit over valid/ready while keeping a frame copy.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned IW         = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [NDIG-1:0]     i_dig,
  input  logic [1:7]          i_seg,
  seg7_scan_capture_if.master out_if,
  output logic                o_ovf,
  output logic [4*NDIG-1:0]   o_frame,
  output logic                o_frame_done
);

  state_t             r_state, w_state_nxt;
  logic [NDIG-1:0]    r_dig;
  logic [1:7]         r_seg;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_same, w_onehot, w_accept;
  logic [3:0]         w_code;
  logic               w_err;
  logic [IW-1:0]      w_idx;
  logic [NDIG-1:0]    r_seen, w_seen_nxt;
  logic               r_valid, r_err, r_ovf, r_frame_done;
  logic [IW-1:0]      r_idx;
  logic [3:0]         r_code;
  logic [4*NDIG-1:0]  r_frame;

  seg7_to_code u_dec (
    .i_seg    (i_seg),
    .o_code_c (w_code),
    .o_err_c  (w_err)
  );

  // Stability counter: compares the incoming sample with the one held in S.
  always_comb begin
    w_same   = ({i_dig, i_seg} == {r_dig, r_seg});
    w_onehot = $onehot(i_dig);
    w_idx    = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (i_dig[i]) w_idx = IW'(i);
    end
    if (w_same && w_onehot) begin
      w_cnt_nxt = (r_cnt >= CNT_W'(STABLE_CNT)) ? r_cnt : r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // HOLD suppresses re-accepting a pair until the sample changes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      w_accept = w_onehot && (w_cnt_nxt == CNT_W'(STABLE_CNT)) &&
                 ((r_state != HOLD) || !w_same);
      case (r_state)
        IDLE:    w_state_nxt = w_accept ? HOLD : TRACK;
        TRACK:   if (w_accept) w_state_nxt = HOLD;
        HOLD:    if (w_accept) w_state_nxt = HOLD;
                 else if (!w_same) w_state_nxt = TRACK;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dig <= '0;
      r_seg <= '0;
      r_cnt <= '0;
    end else if (!i_en) begin
      r_dig <= '0;
      r_seg <= '0;
      r_cnt <= '0;
    end else begin
      r_dig <= i_dig;
      r_seg <= i_seg;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output register: a new accept loads only if the slot is free or draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_code  <= CODE_BLANK;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept && (!r_valid || out_if.ready)) begin
        r_valid <= 1'b1;
        r_idx   <= w_idx;
        r_code  <= w_code;
        r_err   <= w_err;
      end else if (r_valid && out_if.ready) begin
        r_valid <= 1'b0;
      end
      if (!i_en) r_ovf <= 1'b0;
      else if (w_accept && r_valid && !out_if.ready) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_seen_nxt = r_seen;
    if (w_accept) w_seen_nxt = r_seen | (NDIG'(1) << w_idx);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame      <= {NDIG{CODE_BLANK}};
      r_seen       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (w_accept && (w_idx == IW'(i))) r_frame[4*i +: 4] <= w_code;
      end
      r_frame_done <= &w_seen_nxt;
      r_seen       <= (&w_seen_nxt) ? '0 : w_seen_nxt;
    end
  end

  assign out_if.valid = r_valid;
  assign out_if.idx   = r_idx;
  assign out_if.code  = r_code;
  assign out_if.err   = r_err;
  assign o_ovf        = r_ovf;
  assign o_frame      = r_frame;
  assign o_frame_done = r_frame_done;

endmodule
